// File: rtl/interrupt_ctrl_gen.sv
// Parametrised interrupt controller: per-channel edge/level detect, W1C pending, priority dispatch into a code FIFO.
// Optional macro INTERRUPT_CHAN_ID_EN adds the channel index to each FIFO entry (ICHAN port, STATUS[45:40]).
module interrupt_ctrl_gen #(
  parameter int TagWidth   = 4,
  parameter int NCH        = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NCH-1:0]      IRQ,
  input  logic                ACT,
  input  logic                CMD,
  input  logic [4:0]          ADDR,
  input  logic [7:0]          BE,
  input  logic [63:0]         DI,
  input  logic [TagWidth-1:0] TI,
  output logic                DRDY,
  output logic [63:0]         DO,
  output logic [TagWidth-1:0] TO,
  output logic                INTR,
  output logic [15:0]         ICODE,
  input  logic                IACK
`ifdef INTERRUPT_CHAN_ID_EN
  ,
  output logic [5:0]          ICHAN
`endif
);

`ifdef INTERRUPT_CHAN_ID_EN
  localparam int EW = 22;
`else
  localparam int EW = 16;
`endif
  localparam logic [FIFO_AW:0]   CntOne  = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW:0]   CntFull = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] PtrOne  = FIFO_AW'(1);

  logic [NCH-1:0][15:0] code_q, code_d;
  logic [NCH-1:0]       mask_q, mask_d, mode_q, mode_d, pend_q, pend_d, irq_d_q, irq_d_d;
  logic                 ovf_q, ovf_d;
  logic [FIFO_AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [FIFO_AW:0]     cnt_q, cnt_d;
  logic                 drdy_q, drdy_d;
  logic [63:0]          do_q, do_d;
  logic [TagWidth-1:0]  to_q, to_d;
  logic [EW-1:0]        fifo_mem [FIFO_DEPTH];

  logic [63:0]    wbits, rdata, status;
  logic [NCH-1:0] set, disp_oh, w1c;
  logic [EW-1:0]  disp_ent, head;
  logic           wr, rd, full, empty, push, pop;

  assign head  = fifo_mem[rptr_q];
  assign empty = (cnt_q == '0);
  assign INTR  = ~empty;
  assign ICODE = empty ? 16'h0 : head[15:0];
  assign DRDY  = drdy_q;
  assign DO    = do_q;
  assign TO    = to_q;
`ifdef INTERRUPT_CHAN_ID_EN
  assign ICHAN = empty ? 6'h0 : head[21:16];
`endif

  always_comb begin
    for (int b = 0; b < 8; b++) wbits[8*b +: 8] = {8{~BE[b]}};
    wr    = ACT & ~CMD;
    rd    = ACT & CMD;
    full  = (cnt_q == CntFull);
    set   = mask_q & IRQ & (~mode_q | ~irq_d_q);
    // Lowest-index pending channel wins; nothing is picked while the FIFO is full.
    disp_oh  = '0;
    disp_ent = '0;
    push     = 1'b0;
    if (!full) begin
      for (int i = 0; i < NCH; i++) begin
        if (pend_q[i] && !push) begin
          push       = 1'b1;
          disp_oh[i] = 1'b1;
`ifdef INTERRUPT_CHAN_ID_EN
          disp_ent   = {6'(i), code_q[i]};
`else
          disp_ent   = code_q[i];
`endif
        end
      end
    end
    pop = IACK & ~empty;

    status = '0;
    status[FIFO_AW:0] = cnt_q;
    status[32] = ovf_q;
`ifdef INTERRUPT_CHAN_ID_EN
    status[45:40] = empty ? 6'h0 : head[21:16];
`endif
    rdata = '0;
    if (!ADDR[4]) begin
      for (int k = 0; k < NCH/4; k++)
        if (ADDR[3:0] == 4'(k)) rdata = code_q[4*k +: 4];
    end else begin
      case (ADDR[3:0])
        4'd0:    rdata = 64'(mask_q);
        4'd1:    rdata = 64'(mode_q);
        4'd2:    rdata = 64'(pend_q);
        4'd3:    rdata = status;
        default: rdata = '0;
      endcase
    end

    code_d = code_q;
    for (int k = 0; k < NCH/4; k++)
      if (wr && ADDR == 5'(k)) code_d[4*k +: 4] = (code_q[4*k +: 4] & ~wbits) | (DI & wbits);
    // Written MASK bytes override the dispatch auto-clear; unwritten bits still see it.
    mask_d = mask_q & ~disp_oh;
    if (wr && ADDR == 5'd16) mask_d = (mask_d & ~wbits[NCH-1:0]) | (DI[NCH-1:0] & wbits[NCH-1:0]);
    mode_d = mode_q;
    if (wr && ADDR == 5'd17) mode_d = (mode_q & ~wbits[NCH-1:0]) | (DI[NCH-1:0] & wbits[NCH-1:0]);
    w1c    = (wr && ADDR == 5'd18) ? (DI[NCH-1:0] & wbits[NCH-1:0]) : '0;
    pend_d = (pend_q & ~disp_oh & ~w1c) | set;
    ovf_d  = (ovf_q & ~(wr && ADDR == 5'd19 && !BE[4] && DI[32])) | |(set & pend_q);
    irq_d_d = IRQ;

    wptr_d = push ? wptr_q + PtrOne : wptr_q;
    rptr_d = pop  ? rptr_q + PtrOne : rptr_q;
    cnt_d  = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CntOne;
    if (!push && pop) cnt_d = cnt_q - CntOne;

    drdy_d = rd;
    do_d   = rd ? rdata : do_q;
    to_d   = rd ? TI : to_q;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      code_q  <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      irq_d_q <= '0;
      ovf_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      drdy_q  <= 1'b0;
      do_q    <= '0;
      to_q    <= '0;
    end else begin
      code_q  <= code_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      irq_d_q <= irq_d_d;
      ovf_q   <= ovf_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      drdy_q  <= drdy_d;
      do_q    <= do_d;
      to_q    <= to_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && push) fifo_mem[wptr_q] <= disp_ent;
  end

endmodule

// File: tb/tb_interrupt_ctrl_gen.sv
// Bench for interrupt_ctrl_gen: directed register/dispatch scenarios, then random traffic
// against a transaction-level model (queue FIFO, per-channel arrays).
module tb_interrupt_ctrl_gen;
  localparam int NCH = 8, DEPTH = 2, FAW = 1, TW = 4;

  logic CLK = 0, RESET = 0, ACT = 0, CMD = 0, IACK = 0;
  logic [NCH-1:0] IRQ = '0;
  logic [4:0] ADDR = '0;
  logic [7:0] BE = 8'hFF;
  logic [63:0] DI = '0;
  logic [TW-1:0] TI = '0;
  logic DRDY, INTR;
  logic [63:0] DO;
  logic [TW-1:0] TO;
  logic [15:0] ICODE;
`ifdef INTERRUPT_CHAN_ID_EN
  logic [5:0] ICHAN;
`endif

  interrupt_ctrl_gen #(.TagWidth(TW), .NCH(NCH), .FIFO_DEPTH(DEPTH), .FIFO_AW(FAW)) dut (
    .CLK(CLK), .RESET(RESET), .IRQ(IRQ), .ACT(ACT), .CMD(CMD), .ADDR(ADDR), .BE(BE),
    .DI(DI), .TI(TI), .DRDY(DRDY), .DO(DO), .TO(TO), .INTR(INTR), .ICODE(ICODE), .IACK(IACK)
`ifdef INTERRUPT_CHAN_ID_EN
    , .ICHAN(ICHAN)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [15:0] m_code [NCH];
  logic [NCH-1:0] m_mask, m_mode, m_pend, m_irqd;
  bit m_ovf, m_drdy;
  logic [21:0] m_q [$];
  logic [63:0] m_do;
  logic [TW-1:0] m_to;

  function automatic logic [63:0] m_read(input logic [4:0] a);
    logic [63:0] r;
    int ai;
    r = '0;
    ai = int'(a);
    if (ai < 16) begin
      if (4*ai < NCH) for (int j = 0; j < 4; j++) r[16*j +: 16] = m_code[4*ai + j];
    end else if (ai == 16) r[NCH-1:0] = m_mask;
    else if (ai == 17) r[NCH-1:0] = m_mode;
    else if (ai == 18) r[NCH-1:0] = m_pend;
    else if (ai == 19) begin
      r[FAW:0] = (FAW+1)'(m_q.size());
      r[32] = m_ovf;
`ifdef INTERRUPT_CHAN_ID_EN
      if (m_q.size() > 0) r[45:40] = m_q[0][21:16];
`endif
    end
    return r;
  endfunction

  task automatic model_step();
    logic [NCH-1:0] set_v;
    logic [63:0] rdata;
    logic [21:0] ent;
    int disp, pre, ai;
    bit wen, ovf_clr;
    if (!RESET) begin
      for (int i = 0; i < NCH; i++) m_code[i] = '0;
      m_mask = '0; m_mode = '0; m_pend = '0; m_irqd = '0; m_ovf = 0;
      m_q.delete(); m_drdy = 0; m_do = '0; m_to = '0;
      return;
    end
    rdata = m_read(ADDR);
    for (int i = 0; i < NCH; i++)
      set_v[i] = m_mask[i] && (m_mode[i] ? (IRQ[i] && !m_irqd[i]) : IRQ[i]);
    pre = m_q.size();
    disp = -1;
    ent = '0;
    if (pre < DEPTH) for (int i = NCH-1; i >= 0; i--) if (m_pend[i]) disp = i;
    if (disp >= 0) ent = {6'(disp), m_code[disp]};
    ovf_clr = ACT && !CMD && ADDR == 5'd19 && !BE[4] && DI[32];
    m_ovf = (m_ovf && !ovf_clr) || ((set_v & m_pend) != '0);
    for (int i = 0; i < NCH; i++) begin
      wen = ACT && !CMD && !BE[i/8];
      if (i == disp) begin m_pend[i] = 0; m_mask[i] = 0; end
      if (wen && ADDR == 5'd18 && DI[i]) m_pend[i] = 0;
      if (set_v[i]) m_pend[i] = 1;
      if (wen && ADDR == 5'd16) m_mask[i] = DI[i];
      if (wen && ADDR == 5'd17) m_mode[i] = DI[i];
    end
    ai = int'(ADDR);
    if (ACT && !CMD && ai < 16 && 4*ai < NCH)
      for (int b = 0; b < 64; b++) if (!BE[b/8]) m_code[4*ai + b/16][b%16] = DI[b];
    if (IACK && pre > 0) void'(m_q.pop_front());
    if (disp >= 0) m_q.push_back(ent);
    m_irqd = IRQ;
    m_drdy = ACT && CMD;
    if (m_drdy) begin m_do = rdata; m_to = TI; end
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    chk("intr", 64'(INTR), 64'(m_q.size() > 0));
    chk("icode", 64'(ICODE), (m_q.size() > 0) ? 64'(m_q[0][15:0]) : 64'h0);
    chk("drdy", 64'(DRDY), 64'(m_drdy));
    chk("do", DO, m_do);
    chk("to", 64'(TO), 64'(m_to));
`ifdef INTERRUPT_CHAN_ID_EN
    chk("ichan", 64'(ICHAN), (m_q.size() > 0) ? 64'(m_q[0][21:16]) : 64'h0);
`endif
  endtask

  task automatic wr(input logic [4:0] a, input logic [63:0] d, input logic [7:0] be);
    ACT = 1; CMD = 0; ADDR = a; DI = d; BE = be;
    tick();
    ACT = 0; BE = 8'hFF; DI = '0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [63:0] d);
    ACT = 1; CMD = 1; ADDR = a;
    tick();
    ACT = 0; CMD = 0;
    d = DO;
  endtask

  logic [63:0] d;

  initial begin
    // reset
    RESET = 0; tick(); tick(); RESET = 1;
    chk("rst_intr", 64'(INTR), 64'h0);
    chk("rst_icode", 64'(ICODE), 64'h0);
    for (int a = 16; a < 20; a++) begin rd(5'(a), d); chk("rst_rd", d, 64'h0); end

    // code, mask, level irq
    wr(5'd0, 64'h4444_3333_2222_1111, 8'h00);
    wr(5'd16, 64'hF, 8'h00);
    IRQ = 8'h04; tick();
    IRQ = 8'h00; tick();
    chk("t2_icode", 64'(ICODE), 64'h3333);
    chk("t2_intr", 64'(INTR), 64'h1);
    rd(5'd16, d); chk("t2_mask", d, 64'hB);
    IACK = 1; tick(); IACK = 0;
    chk("t2_ack", 64'(INTR), 64'h0);

    // priority and edge mode
    wr(5'd17, 64'h3, 8'h00);
    wr(5'd16, 64'h3, 8'h00);
    IRQ = 8'h03; tick(); tick(); tick();
    chk("t3_first", 64'(ICODE), 64'h1111);
    IACK = 1; tick();
    chk("t3_second", 64'(ICODE), 64'h2222);
    tick(); IACK = 0;
    chk("t3_empty", 64'(INTR), 64'h0);
    repeat (4) tick();
    chk("t3_noretrig", 64'(INTR), 64'h0);

    // full FIFO
    IRQ = 8'h00;
    wr(5'd17, 64'h0, 8'h00);
    wr(5'd16, 64'h7, 8'h00);
    IRQ = 8'h07; tick();
    IRQ = 8'h00; tick(); tick();
    rd(5'd19, d); chk("t4_cnt", 64'(d[31:0]), 64'd2);
    rd(5'd18, d); chk("t4_pend", d, 64'h4);
    IACK = 1; tick(); IACK = 0; tick();
    rd(5'd19, d); chk("t4_cnt2", 64'(d[31:0]), 64'd2);
    rd(5'd18, d); chk("t4_pend2", d, 64'h0);
    chk("t4_head", 64'(ICODE), 64'h2222);

    // overflow and W1C while full
    wr(5'd1, 64'h8888_7777_6666_5555, 8'h00);
    wr(5'd17, 64'h20, 8'h00);
    wr(5'd16, 64'h20, 8'h00);
    IRQ = 8'h20; tick(); IRQ = 8'h00; tick(); IRQ = 8'h20; tick(); IRQ = 8'h00;
    rd(5'd19, d); chk("t5_ovf", 64'(d[32]), 64'h1);
    rd(5'd18, d); chk("t5_pend", d, 64'h20);
    wr(5'd18, 64'h20, 8'hFE);
    rd(5'd18, d); chk("t5_w1c", d, 64'h0);
    wr(5'd19, 64'h1 << 32, 8'hEF);
    rd(5'd19, d); chk("t5_ovfclr", 64'(d[32:0]), 64'd2);

    // read tag and latency
    TI = 4'hA; rd(5'd19, d); TI = 4'h0;
    chk("t6_drdy", 64'(DRDY), 64'h1);
    chk("t6_to", 64'(TO), 64'hA);
    rd(5'd25, d); chk("t6_unmapped", d, 64'h0);
    tick();
    chk("t6_drdy_low", 64'(DRDY), 64'h0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      RESET = ($urandom_range(0, 99) != 0);
      ACT   = $urandom_range(0, 1);
      CMD   = $urandom_range(0, 1);
      ADDR  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(16, 19)) : 5'($urandom_range(0, 31));
      BE    = 8'($urandom);
      DI    = {$urandom, $urandom};
      IRQ   = NCH'($urandom);
      IACK  = ($urandom_range(0, 2) == 0);
      TI    = TW'($urandom);
      tick();
    end
    RESET = 1; ACT = 0; IACK = 0; IRQ = '0;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
